shiftadd_seq_ctrl: RTL and testbench

//   Sequential shift-add multiplier with controller. Unsigned WIDTH x WIDTH multiply,
//   one partial product per clock, start/done handshake.

---
 rtl/shiftadd_pkg.sv | 20 ++
 rtl/shiftadd_seq_ctrl_if.sv | 22 ++
 rtl/shiftadd_seq_dp.sv | 52 +++++
 rtl/shiftadd_seq_ctrl.sv | 99 +++++++++
 tb/tb_shiftadd_seq_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/shiftadd_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package shiftadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bits needed to hold iteration indices 0..width-1 (at least 1).
    function automatic int clog2(input int width);
        int bits;
        bits = 1;
        while ((1 << bits) < width) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/shiftadd_seq_ctrl_if.sv
// Host-side start/done handshake, operands and product of the shift-add multiplier.
interface shiftadd_seq_ctrl_if #(parameter int WIDTH = 4);

    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );

endinterface

// File: rtl/shiftadd_seq_dp.sv
// Datapath: accumulator, shifting multiplicand A and multiplier Q, one shared adder.
// SHIFTADD_EARLY_EXIT_EN adds the q_rest_zero status used for early termination.
module shiftadd_seq_dp #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 commit,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
`ifdef SHIFTADD_EARLY_EXIT_EN
    output logic                 q_rest_zero,
`endif
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a;
    logic [WIDTH-1:0]   q;
    logic [2*WIDTH-1:0] sum;

    assign sum = acc + (q[0] ? a : '0);

`ifdef SHIFTADD_EARLY_EXIT_EN
    assign q_rest_zero = (q[WIDTH-1:1] == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            a       <= '0;
            q       <= '0;
            product <= '0;
        end else begin
            if (load) begin
                acc <= '0;
                a   <= {{WIDTH{1'b0}}, multiplicand};
                q   <= multiplier;
            end else if (step) begin
                acc <= sum;
                a   <= a << 1;
                q   <= q >> 1;
            end
            if (commit) begin
                product <= sum;
            end
        end
    end

endmodule

// File: rtl/shiftadd_seq_ctrl.sv
// Sequential shift-add multiplier: control FSM and iteration counter around shiftadd_seq_dp.
// Define SHIFTADD_EARLY_EXIT_EN to stop once the remaining multiplier bits are all zero.
//   state | meaning
//   IDLE  | ready for start; operands loaded into datapath on accept
//   RUN   | one partial product per clock
//   DONE  | one-cycle done pulse, product valid
module shiftadd_seq_ctrl
    import shiftadd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shiftadd_seq_ctrl_if.slave    bus
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          load;
    logic          step;
    logic          commit;
    logic          last;

`ifdef SHIFTADD_EARLY_EXIT_EN
    logic q_rest_zero;
    assign last = (count == LAST_COUNT) || q_rest_zero;
`else
    assign last = (count == LAST_COUNT);
`endif

    assign load   = (state == IDLE) && bus.start;
    assign step   = (state == RUN);
    assign commit = step && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        count   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (last) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    shiftadd_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .step         (step),
        .commit       (commit),
        .multiplicand (bus.multiplicand),
        .multiplier   (bus.multiplier),
`ifdef SHIFTADD_EARLY_EXIT_EN
        .q_rest_zero  (q_rest_zero),
`endif
        .product      (bus.product)
    );

endmodule

// File: tb/tb_shiftadd_seq_ctrl.sv
// Self-checking bench for shiftadd_seq_ctrl against an arithmetic reference (a*b, iteration count).
module tb_shiftadd_seq_ctrl;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    shiftadd_seq_ctrl_if #(.WIDTH(W)) bus ();

    shiftadd_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    function automatic int ref_latency(input logic [W-1:0] b);
`ifdef SHIFTADD_EARLY_EXIT_EN
        int msb;
        msb = 0;
        for (int i = 0; i < W; i++) if (b[i]) msb = i + 1;
        return (msb < 1) ? 1 : msb;
`else
        return W;
`endif
    endfunction

    // Issue one multiply, count edges to done, check product, pulse width and hold.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int   edges;
        logic got;
        logic [2*W-1:0] exp_p;
        exp_p = ref_product(a, b);
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1) $display("FAIL %s ready_before_start got=%b exp=1", tag, bus.ready);
        else n_pass++;
        bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.multiplicand = W'($urandom); bus.multiplier = W'($urandom);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0)
            $display("FAIL %s busy_after_accept got busy=%b ready=%b exp busy=1 ready=0", tag, bus.busy, bus.ready);
        else n_pass++;
        edges = 0; got = 1'b0;
        for (int i = 0; i < 4*W + 4; i++) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got) $display("FAIL %s done_timeout got=no_done exp=done", tag);
        else n_pass++;
        n_checks++;
        if (edges !== ref_latency(b)) $display("FAIL %s latency got=%0d exp=%0d", tag, edges, ref_latency(b));
        else n_pass++;
        n_checks++;
        if (bus.product !== exp_p) $display("FAIL %s product got=%0d exp=%0d", tag, bus.product, exp_p);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.product !== exp_p)
            $display("FAIL %s after_done got done=%b ready=%b busy=%b p=%0d exp done=0 ready=1 busy=0 p=%0d",
                     tag, bus.done, bus.ready, bus.busy, bus.product, exp_p);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        #12;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0)
            $display("FAIL reset got ready=%b busy=%b done=%b p=%0d exp 1 0 0 0",
                     bus.ready, bus.busy, bus.done, bus.product);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        do_mul(4'b0011, 4'b0010, "first_3x2");
    endtask

    task automatic test_sequence();
        logic [2*W-1:0] held;
        do_mul(4'b0101, 4'b0011, "seq_5x3");
        do_mul(4'b0111, 4'b0101, "seq_7x5");
        held = bus.product;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.product !== 8'd35 || bus.done !== 1'b0)
                $display("FAIL hold_idle got p=%0d done=%b exp p=35 done=0", bus.product, bus.done);
            else n_pass++;
        end
        do_mul(4'b1000, 4'b0011, "seq_8x3");
    endtask

    task automatic test_corners();
        do_mul(4'b1111, 4'b1111, "corner_15x15");
        do_mul(4'b0000, 4'b1011, "corner_0x11");
        do_mul(4'b1011, 4'b0000, "corner_11x0");
`ifdef SHIFTADD_EARLY_EXIT_EN
        do_mul(4'b0101, 4'b0001, "early_5x1");
        do_mul(4'b0101, 4'b0010, "early_5x2");
        do_mul(4'b0101, 4'b1000, "early_5x8");
`endif
    endtask

    task automatic test_ignore_start();
        int   edges;
        logic got;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'd5; bus.multiplier = 4'd3;
        @(posedge clk); #1;
        bus.multiplicand = 4'd9; bus.multiplier = 4'd7;
        edges = 0; got = 1'b0;
        for (int i = 0; i < 4*W + 4; i++) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || edges !== ref_latency(4'd3) || bus.product !== 8'd15)
            $display("FAIL ignore_first got done=%b edges=%0d p=%0d exp done=1 edges=%0d p=15",
                     got, edges, bus.product, ref_latency(4'd3));
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.product !== 8'd15)
            $display("FAIL ignore_in_done got ready=%b busy=%b p=%0d exp ready=1 busy=0 p=15",
                     bus.ready, bus.busy, bus.product);
        else n_pass++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL reaccept got ready=%b busy=%b exp ready=0 busy=1", bus.ready, bus.busy);
        else n_pass++;
        edges = 0; got = 1'b0;
        for (int i = 0; i < 4*W + 4; i++) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || edges !== ref_latency(4'd7) || bus.product !== 8'd63)
            $display("FAIL reaccept_result got done=%b edges=%0d p=%0d exp done=1 edges=%0d p=63",
                     got, edges, bus.product, ref_latency(4'd7));
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'b0111; bus.multiplier = 4'b0101;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0)
            $display("FAIL abort_reset got ready=%b busy=%b done=%b p=%0d exp 1 0 0 0",
                     bus.ready, bus.busy, bus.done, bus.product);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.product !== '0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) $display("FAIL abort_no_done got done_or_product_change exp none");
        else n_pass++;
        do_mul(4'b0011, 4'b0010, "after_abort_3x2");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 20; k++) begin
            do_mul(W'($urandom), W'($urandom), $sformatf("rand_%0d", k));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_sequence();
        test_corners();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
